// File: rtl/pong_paddle_ctrl.sv
// pong_paddle_ctrl: key sync/debounce and per-frame paddle position integration for two players.
// Optional PADDLE_ACCEL_EN doubles the step after a paddle is held in one direction for 15 ticks.
module pong_paddle_ctrl #(
  parameter int DEB_CYCLES   = 250000,
  parameter int FRAME_CYCLES = 420000,
  parameter int STEP         = 4,
  parameter int PADDLE_H     = 80,
  parameter int Y_MAX        = 480,
  parameter int Y_INIT       = 200
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic [1:0] key0,
  input  logic [1:0] key1,
  output logic [3:0] key_db,
  output logic [9:0] paddle0_y,
  output logic [9:0] paddle1_y,
  output logic       frame_tick,
  output logic [1:0] paddle_moved
);
  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam int FW = $clog2(FRAME_CYCLES) + 1;
  localparam logic [10:0] Y_LIM = 11'(Y_MAX - PADDLE_H);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  logic [3:0]    r_sync1, r_sync2, r_key_db;
  logic [DW-1:0] r_deb_cnt [4];
  logic [FW-1:0] r_fcnt, w_fcnt_nxt;
  logic          r_tick;
  logic [9:0]    w_y [2];
  logic [1:0]    w_moved;
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_key_db <= '1;
      for (int i = 0; i < 4; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= {key1, key0};
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++)
        if (r_sync2[i] == r_key_db[i]) r_deb_cnt[i] <= '0;
        else if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          r_key_db[i]  <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
    end
  end
  assign w_fcnt_nxt = (r_fcnt == FW'(FRAME_CYCLES - 1)) ? '0 : r_fcnt + 1'b1;
  // tick is registered one cycle ahead so it is high exactly while the count is at its last value
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_fcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_fcnt <= w_fcnt_nxt;
      r_tick <= (w_fcnt_nxt == FW'(FRAME_CYCLES - 1));
    end
  end
  for (genvar p = 0; p < 2; p++) begin : g_pad
    state_t      r_state, w_next;
    logic [9:0]  r_y;
    logic        r_moved, w_up, w_dn;
    logic [10:0] w_step, w_y11, w_y_nxt;
    assign w_up   = ~r_key_db[2*p];
    assign w_dn   = ~r_key_db[2*p+1];
    assign w_next = (w_up && !w_dn) ? UP : (w_dn && !w_up) ? DOWN : IDLE;
`ifdef PADDLE_ACCEL_EN
    logic [3:0] r_hold, w_hold_nxt;
    assign w_hold_nxt = (w_next != IDLE && w_next == r_state) ? ((r_hold == 4'd15) ? 4'd15 : r_hold + 4'd1) : 4'd0;
    assign w_step     = (w_hold_nxt == 4'd15) ? 11'(2 * STEP) : 11'(STEP);
    always_ff @(posedge vga_clk) begin
      if (sys_rst) r_hold <= 4'd0;
      else if (r_tick) r_hold <= w_hold_nxt;
    end
`else
    assign w_step = 11'(STEP);
`endif
    assign w_y11   = {1'b0, r_y};
    assign w_y_nxt = (w_next == UP)   ? ((w_y11 < w_step) ? 11'd0 : w_y11 - w_step) :
                     (w_next == DOWN) ? ((w_y11 + w_step > Y_LIM) ? Y_LIM : w_y11 + w_step) : w_y11;
    always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
        r_state <= IDLE;
        r_y     <= 10'(Y_INIT);
        r_moved <= 1'b0;
      end else begin
        r_moved <= r_tick && (w_y_nxt[9:0] != r_y);
        if (r_tick) begin
          r_state <= w_next;
          r_y     <= w_y_nxt[9:0];
        end
      end
    end
    assign w_y[p]     = r_y;
    assign w_moved[p] = r_moved;
  end
  assign key_db       = r_key_db;
  assign paddle0_y    = w_y[0];
  assign paddle1_y    = w_y[1];
  assign frame_tick   = r_tick;
  assign paddle_moved = w_moved;
endmodule
